// File: rtl/keypad_emulator_if.sv
// Keypad emulator bus interface.
// Bundles the scanner-facing matrix lines and the press request handshake.
//   col         : active-low column strobe from the matrix scanner
//   press_valid : request to press the key on press_key
//   press_key   : key index 0-15 (row_bit*4 + col_bit)
//   press_ready : a request can be accepted
//   row         : active-low row lines back to the scanner (4'b1111 = no key)
//   busy        : a press/release cycle is in progress
//   done        : one-cycle pulse when a press/release cycle completes
// master = request/scanner side, slave = emulator.
interface keypad_emulator_if;
   logic [3:0] col;
   logic       press_valid;
   logic [3:0] press_key;
   logic       press_ready;
   logic [3:0] row;
   logic       busy;
   logic       done;

   modport master (
      output col, press_valid, press_key,
      input  press_ready, row, busy, done
   );

   modport slave (
      input  col, press_valid, press_key,
      output press_ready, row, busy, done
   );
endinterface

// File: rtl/keypad_emulator.sv
// Keypad emulator: drives the row lines of a 4x4 key matrix as if one key were
// pressed for HOLD_CYCLES and then released for RELEASE_CYCLES.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : keypad_emulator_if.slave (col, press_valid, press_key in;
//           press_ready, row, busy, done out)
// Optional feature: define KEYEMU_BOUNCE_EN to emulate contact bounce during the
// first BOUNCE_CYCLES of each press (row drive alternates every BOUNCE_PERIOD).
module keypad_emulator #(
   parameter logic [31:0] HOLD_CYCLES    = 32'd3000_000,
   parameter logic [31:0] RELEASE_CYCLES = 32'd3000_000,
   parameter logic [31:0] BOUNCE_CYCLES  = 32'd500_000,
   parameter logic [31:0] BOUNCE_PERIOD  = 32'd50_000
) (
   input  logic               clk,
   input  logic               rst_n,
   keypad_emulator_if.slave   bus
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PRESS   = 2'd1;
   localparam logic [1:0] RELEASE = 2'd2;

   // Terminal counter values; a zero length behaves as one cycle.
   localparam logic [31:0] HOLD_LAST = (HOLD_CYCLES    == 32'd0) ? 32'd0 : HOLD_CYCLES - 32'd1;
   localparam logic [31:0] REL_LAST  = (RELEASE_CYCLES == 32'd0) ? 32'd0 : RELEASE_CYCLES - 32'd1;

   logic [1:0]  state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [3:0]  key_q, key_d;
   logic [3:0]  row_q, row_d;
   logic        done_q, done_d;
   logic        drive_en;

`ifdef KEYEMU_BOUNCE_EN
   localparam logic [31:0] BPER_LAST = (BOUNCE_PERIOD == 32'd0) ? 32'd0 : BOUNCE_PERIOD - 32'd1;

   // bcnt_q counts within a bounce interval; bphase_q is set in odd intervals.
   logic [31:0] bcnt_q, bcnt_d;
   logic        bphase_q, bphase_d;

   always_comb begin
      bcnt_d   = bcnt_q;
      bphase_d = bphase_q;
      if (state_q == IDLE) begin
         bcnt_d   = 32'd0;
         bphase_d = 1'b0;
      end else if (state_q == PRESS) begin
         if (bcnt_q == BPER_LAST) begin
            bcnt_d   = 32'd0;
            bphase_d = ~bphase_q;
         end else begin
            bcnt_d = bcnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcnt_q   <= 32'd0;
         bphase_q <= 1'b0;
      end else begin
         bcnt_q   <= bcnt_d;
         bphase_q <= bphase_d;
      end
   end

   assign drive_en = (cnt_q >= BOUNCE_CYCLES) || !bphase_q;
`else
   assign drive_en = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      done_d  = 1'b0;
      row_d   = 4'b1111;

      case (state_q)
         IDLE: begin
            if (bus.press_valid) begin
               key_d   = bus.press_key;
               cnt_d   = 32'd0;
               state_d = PRESS;
            end
         end
         PRESS: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = RELEASE;
               cnt_d   = 32'd0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         RELEASE: begin
            // The done cycle is spent still in RELEASE so a request seen
            // alongside done is not taken; IDLE follows on the next edge.
            if (done_q) begin
               state_d = IDLE;
               cnt_d   = 32'd0;
            end else if (cnt_q == REL_LAST) begin
               done_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Only drive a row while the press continues into the next cycle, so the
      // registered row is released together with the PRESS->RELEASE step.
      if (state_q == PRESS && state_d == PRESS && drive_en &&
          bus.col == ~(4'b0001 << key_q[1:0])) begin
         row_d = ~(4'b0001 << key_q[3:2]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 32'd0;
         key_q   <= 4'd0;
         row_q   <= 4'b1111;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         row_q   <= row_d;
         done_q  <= done_d;
      end
   end

   assign bus.press_ready = (state_q == IDLE);
   assign bus.busy        = (state_q != IDLE);
   assign bus.row         = row_q;
   assign bus.done        = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator. A timeline model predicts every
// output from the cycle distance to the last accepted request.
module tb_keypad_emulator;

   localparam int H  = 20;
   localparam int R  = 10;
   localparam int BC = 8;
   localparam int BP = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   keypad_emulator_if kif ();

   keypad_emulator #(
      .HOLD_CYCLES    (32'd20),
      .RELEASE_CYCLES (32'd10),
      .BOUNCE_CYCLES  (32'd8),
      .BOUNCE_PERIOD  (32'd2)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (kif)
   );

   int         n_vec    = 0;
   int         n_err    = 0;
   int         cyc      = 0;
   int         t0       = -1;      // cycle in which the live request was accepted
   logic [3:0] mkey     = 4'd0;
   logic [3:0] col_prev = 4'b1111;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit bounce_on(input int c);
`ifdef KEYEMU_BOUNCE_EN
      return (c >= BC) || (((c / BP) % 2) == 0);
`else
      return 1'b1;
`endif
   endfunction

   // Cycles since acceptance; PRESS is d=1..H, RELEASE d=H+1..H+R, done at
   // d=H+R+1 (still busy), idle again from d=H+R+2.
   function automatic bit model_busy();
      int d;
      d = cyc - t0;
      return (t0 >= 0) && (d >= 1) && (d <= H + R + 1);
   endfunction

   // Checks outputs of the current cycle, applies inputs, advances one clock.
   task automatic step(input logic [3:0] c, input logic v, input logic [3:0] k);
      int         d;
      logic [3:0] erow;
      logic [3:0] sel_col;
      d       = cyc - t0;
      erow    = 4'b1111;
      sel_col = ~(4'b0001 << mkey[1:0]);
      if (t0 >= 0 && d >= 2 && d <= H && col_prev == sel_col && bounce_on(d - 2))
         erow = ~(4'b0001 << mkey[3:2]);
      check_eq("row",   {28'd0, kif.row},         {28'd0, erow});
      check_eq("busy",  {31'd0, kif.busy},        {31'd0, model_busy()});
      check_eq("ready", {31'd0, kif.press_ready}, {31'd0, !model_busy()});
      check_eq("done",  {31'd0, kif.done},        {31'd0, (t0 >= 0 && d == H + R + 1)});
      if (!model_busy() && v) begin
         t0   = cyc;
         mkey = k;
      end
      kif.col         = c;
      kif.press_valid = v;
      kif.press_key   = k;
      col_prev        = c;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   logic [3:0] walk [4];
   logic [3:0] oh;

   initial begin
      walk[0] = 4'b1110;
      walk[1] = 4'b1101;
      walk[2] = 4'b1011;
      walk[3] = 4'b0111;
      kif.col         = 4'b1111;
      kif.press_valid = 1'b0;
      kif.press_key   = 4'd0;

      // Reset values while rst_n is held low.
      #12;
      check_eq("rst_row",   {28'd0, kif.row},         32'hF);
      check_eq("rst_ready", {31'd0, kif.press_ready}, 32'd1);
      check_eq("rst_busy",  {31'd0, kif.busy},        32'd0);
      check_eq("rst_done",  {31'd0, kif.done},        32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Key 6 with its column held.
      step(4'b1011, 1'b1, 4'd6);
      for (int i = 0; i < 35; i++) step(4'b1011, 1'b0, 4'd0);

      // Key 13 while the scanner walks the columns.
      step(4'b1110, 1'b1, 4'd13);
      for (int i = 0; i < 35; i++) step(walk[i % 4], 1'b0, 4'd0);

      // Key 0 with multi-low / no-low columns mixed with its own column.
      step(4'b1100, 1'b1, 4'd0);
      for (int i = 0; i < 35; i++)
         step((i % 3 == 0) ? 4'b1100 : ((i % 3 == 1) ? 4'b1111 : 4'b1110), 1'b0, 4'd0);

      // press_valid held high: requests in PRESS and in the done cycle must be
      // ignored and the key of the accepted request must persist.
      for (int i = 0; i < 100; i++) begin
         oh = 4'b0001 << $urandom_range(0, 3);
         step(~oh, 1'b1, 4'($urandom_range(0, 15)));
      end

      // Reset asserted during PRESS cycle 5.
      for (int i = 0; i < 40 && model_busy(); i++) step(4'b1111, 1'b0, 4'd0);
      step(4'b1110, 1'b1, 4'd0);
      for (int i = 0; i < 4; i++) step(4'b1110, 1'b0, 4'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_row",   {28'd0, kif.row},         32'hF);
      check_eq("mid_rst_ready", {31'd0, kif.press_ready}, 32'd1);
      check_eq("mid_rst_busy",  {31'd0, kif.busy},        32'd0);
      check_eq("mid_rst_done",  {31'd0, kif.done},        32'd0);
      t0 = -1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc++;
      for (int i = 0; i < 40; i++) step(4'b1110, 1'b0, 4'd0);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         logic [3:0] c;
         case ($urandom_range(0, 3))
            0:       c = ~(4'b0001 << mkey[1:0]);
            1: begin
               oh = 4'b0001 << $urandom_range(0, 3);
               c  = ~oh;
            end
            2:       c = 4'b1111;
            default: c = 4'($urandom_range(0, 15));
         endcase
         step(c, ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
